varredor_de_registradores: RTL and testbench
============================================

VARREDOR_DE_REGISTRADORES -- requirements
Module: varredor_de_registradores

Interface
REQ-001 The block SHALL have one parameter: DWELL_CYCLES, default 50000000, the number of clock cycles each register value is held on the display before re-sampling (legal range 1 to 2^26).
REQ-002 The block SHALL use one clock and an active-low asynchronous reset, with ports in this order:
- vr_in_clk  in  1  clock
- vr_in_rst_n  in  1  reset, asynchronous, active-low
REQ-003 The block SHALL have the following board-side inputs:
- vr_in_SW  in  5  board switches selecting the register index (asynchronous to vr_in_clk)
- vr_in_auto  in  1  1 = auto-scan mode, 0 = manual mode (asynchronous)
- vr_in_hold  in  1  1 = freeze the display and the scan (asynchronous)
REQ-004 The block SHALL have the following register-file read port:
- vr_in_data  in  32  read data returned by the register file for vr_out_sel; combinational, valid one cycle after vr_out_sel changes
- vr_out_sel  out  5  register index driven to the register file's board read-select port
REQ-005 The block SHALL have the following display outputs:
- vr_out_hex0..vr_out_hex7  out  7 each  active-low seven-segment digits; hex0 = data[3:0], up to hex7 = data[31:28]; bit6..bit0 = segments g..a
- vr_out_ledr  out  5  index of the value currently displayed
- vr_out_valid  out  1  1 = displayed digits correspond to the current vr_out_ledr

Function
REQ-006 vr_in_SW, vr_in_auto and vr_in_hold SHALL each pass through a two-flop synchronizer; all logic below SHALL use only the synchronized versions.
REQ-007 The FSM SHALL have four states and SHALL move one state per clock in this sequence:
- SEL -> WAIT -> CAP -> DWELL
- DWELL -> SEL, under the conditions in REQ-010 and REQ-011
REQ-008 In SEL, the block SHALL register vr_out_sel with the target index:
- manual mode: the synchronized SW value
- auto mode: the previous index + 1, modulo 32 (31 wraps to 0)
- first SEL after reset in auto mode: index 0
REQ-009 In WAIT, the block SHALL hold vr_out_sel so that the register-file read can settle; in CAP, it SHALL register vr_in_data into a 32-bit shadow, register the decoded hex digits and vr_out_ledr = vr_out_sel, and set vr_out_valid = 1, all visible the cycle after CAP.
REQ-010 In DWELL, the dwell counter SHALL increment each cycle; when it reaches DWELL_CYCLES-1 the counter SHALL clear and the FSM SHALL go to SEL to re-sample, so that register writes appear on the display.
REQ-011 In manual mode, if the synchronized SW value differs from vr_out_ledr while in DWELL, the block SHALL go to SEL on the next cycle, clear the counter and drive vr_out_valid = 0 until the next CAP; worst-case latency from the SW pin change to new digits is 7 cycles.
REQ-012 While synchronized hold = 1 in DWELL, the counter, SW-change detection and all outputs SHALL be frozen; if hold asserts in SEL, WAIT or CAP, the sequence SHALL complete and then freeze in DWELL.
REQ-013 A mode change SHALL take effect at the next SEL; auto -> manual SHALL load SW, and manual -> auto SHALL continue from the displayed index + 1.
REQ-014 The hex decoder SHALL map nibbles 0-F to a standard active-low font, e.g. 0 = 1000000, 8 = 0000000, F = 0001110, with b and d shown in lowercase.

Reset
REQ-015 While vr_in_rst_n = 0, the block SHALL immediately, independent of the clock, drive:
- vr_out_sel = 0, vr_out_ledr = 0, vr_out_valid = 0
- all hex outputs = 1111111 (blank)
- FSM state = SEL, counter = 0, shadow = 0, synchronizers = 0
REQ-016 Reset asserted mid-sequence SHALL abandon the capture; after release, the first CAP SHALL occur on the 3rd rising edge.

Configuration
REQ-017 When VARREDOR_AUTO_SCAN_EN is defined, the block SHALL compile in auto-scan mode exactly as specified above.
REQ-018 When VARREDOR_AUTO_SCAN_EN is undefined, vr_in_auto SHALL be ignored, the block SHALL always operate in manual mode, and the auto-index increment logic SHALL be absent.

Verification
REQ-019 The bench SHALL cover reset: with rst_n low mid-DWELL, all hex outputs = 1111111 and valid = 0 immediately; after release with SW = 5 and data = 0x12345678, the bench SHALL check hex7..hex0 = 1,2,3,4,5,6,7,8, ledr = 5 and valid = 1.
REQ-020 The bench SHALL cover manual selection: with SW changed 5 -> 29 and data = 0xDEADBEEF, valid drops within 4 cycles and the digits show DEADBEEF with ledr = 29 within 7 cycles.
REQ-021 The bench SHALL cover auto-scan wrap: with DWELL_CYCLES = 4, auto = 1 and start index 30, the bench SHALL check the sel sequence 31, 0, 1 with new digits every 7 cycles.
REQ-022 The bench SHALL cover re-sampling: with data changed from 0 to 0x0000000F in DWELL and DWELL_CYCLES = 10, hex0 = 0001110 within 13 cycles with no SW change.
REQ-023 The bench SHALL cover hold: with hold = 1 during DWELL and SW changed, the outputs stay unchanged for 100 cycles; after hold = 0, the new index is displayed within 7 cycles.
REQ-024 The bench SHALL cover the build without VARREDOR_AUTO_SCAN_EN: with auto = 1 and SW = 3, sel stays at 3 across 5 dwell periods.

Source files
------------

// File: rtl/varredor_de_registradores.sv
// Register-file scanner: samples one register through the board read port and shows it on eight
// seven-segment digits. Define VARREDOR_AUTO_SCAN_EN to build in the auto-scan mode.
module varredor_de_registradores #(
  parameter int unsigned DWELL_CYCLES = 50000000
) (
  input  logic        vr_in_clk,
  input  logic        vr_in_rst_n,
  input  logic [4:0]  vr_in_SW,
  input  logic        vr_in_auto,
  input  logic        vr_in_hold,
  input  logic [31:0] vr_in_data,
  output logic [4:0]  vr_out_sel,
  output logic [6:0]  vr_out_hex0,
  output logic [6:0]  vr_out_hex1,
  output logic [6:0]  vr_out_hex2,
  output logic [6:0]  vr_out_hex3,
  output logic [6:0]  vr_out_hex4,
  output logic [6:0]  vr_out_hex5,
  output logic [6:0]  vr_out_hex6,
  output logic [6:0]  vr_out_hex7,
  output logic [4:0]  vr_out_ledr,
  output logic        vr_out_valid
);

  typedef enum logic [1:0] {ST_SEL, ST_WAIT, ST_CAP, ST_DWELL} state_t;

  localparam logic [26:0] LAST_CNT = 27'(DWELL_CYCLES - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic [4:0]  r_swMeta;
  logic [4:0]  r_swSync;
  logic        r_holdMeta;
  logic        r_holdSync;
  logic [26:0] r_cnt;
  logic [31:0] r_shadow;
  logic        r_blank;
  logic        w_auto;
  logic [4:0]  w_nextSel;
  logic        w_swChange;
  logic        w_cntDone;

  always_ff @(posedge vr_in_clk or negedge vr_in_rst_n) begin
    if (!vr_in_rst_n) begin
      r_swMeta   <= '0;
      r_swSync   <= '0;
      r_holdMeta <= 1'b0;
      r_holdSync <= 1'b0;
    end else begin
      r_swMeta   <= vr_in_SW;
      r_swSync   <= r_swMeta;
      r_holdMeta <= vr_in_hold;
      r_holdSync <= r_holdMeta;
    end
  end

`ifdef VARREDOR_AUTO_SCAN_EN
  logic r_autoMeta;
  logic r_autoSync;
  logic r_first;

  always_ff @(posedge vr_in_clk or negedge vr_in_rst_n) begin
    if (!vr_in_rst_n) begin
      r_autoMeta <= 1'b0;
      r_autoSync <= 1'b0;
      r_first    <= 1'b1;
    end else begin
      r_autoMeta <= vr_in_auto;
      r_autoSync <= r_autoMeta;
      if (r_state == ST_SEL)
        r_first <= 1'b0;
    end
  end

  assign w_auto    = r_autoSync;
  // Auto mode steps from whatever is displayed, so manual -> auto continues from there.
  assign w_nextSel = !w_auto ? r_swSync : (r_first ? 5'd0 : vr_out_ledr + 5'd1);
`else
  logic w_unusedAuto;
  assign w_unusedAuto = vr_in_auto;
  assign w_auto       = 1'b0;
  assign w_nextSel    = r_swSync;
`endif

  assign w_swChange = !w_auto && (r_swSync != vr_out_ledr);
  assign w_cntDone  = (r_cnt == LAST_CNT);

  always_ff @(posedge vr_in_clk or negedge vr_in_rst_n) begin
    if (!vr_in_rst_n)
      r_state <= ST_SEL;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_SEL:   w_nextState = ST_WAIT;
      ST_WAIT:  w_nextState = ST_CAP;
      ST_CAP:   w_nextState = ST_DWELL;
      ST_DWELL: if (!r_holdSync && (w_swChange || w_cntDone)) w_nextState = ST_SEL;
      default:  w_nextState = ST_SEL;
    endcase
  end

  always_ff @(posedge vr_in_clk or negedge vr_in_rst_n) begin
    if (!vr_in_rst_n) begin
      vr_out_sel   <= '0;
      vr_out_ledr  <= '0;
      vr_out_valid <= 1'b0;
      r_shadow     <= '0;
      r_blank      <= 1'b1;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        ST_SEL: vr_out_sel <= w_nextSel;
        ST_CAP: begin
          r_shadow     <= vr_in_data;
          vr_out_ledr  <= vr_out_sel;
          vr_out_valid <= 1'b1;
          r_blank      <= 1'b0;
        end
        ST_DWELL: begin
          // Hold freezes the counter and the switch-change detection together.
          if (!r_holdSync) begin
            if (w_swChange || w_cntDone) begin
              r_cnt <= '0;
              if (w_swChange)
                vr_out_valid <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 27'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] hexFont(input logic [3:0] n);
    hexFont = 7'h7F;
    case (n)
      4'h0: hexFont = 7'b1000000;
      4'h1: hexFont = 7'b1111001;
      4'h2: hexFont = 7'b0100100;
      4'h3: hexFont = 7'b0110000;
      4'h4: hexFont = 7'b0011001;
      4'h5: hexFont = 7'b0010010;
      4'h6: hexFont = 7'b0000010;
      4'h7: hexFont = 7'b1111000;
      4'h8: hexFont = 7'b0000000;
      4'h9: hexFont = 7'b0010000;
      4'hA: hexFont = 7'b0001000;
      4'hB: hexFont = 7'b0000011;
      4'hC: hexFont = 7'b1000110;
      4'hD: hexFont = 7'b0100001;
      4'hE: hexFont = 7'b0000110;
      4'hF: hexFont = 7'b0001110;
      default: hexFont = 7'h7F;
    endcase
  endfunction

  // Digits come straight from the captured shadow; blank until the first capture after reset.
  assign vr_out_hex0 = r_blank ? 7'h7F : hexFont(r_shadow[3:0]);
  assign vr_out_hex1 = r_blank ? 7'h7F : hexFont(r_shadow[7:4]);
  assign vr_out_hex2 = r_blank ? 7'h7F : hexFont(r_shadow[11:8]);
  assign vr_out_hex3 = r_blank ? 7'h7F : hexFont(r_shadow[15:12]);
  assign vr_out_hex4 = r_blank ? 7'h7F : hexFont(r_shadow[19:16]);
  assign vr_out_hex5 = r_blank ? 7'h7F : hexFont(r_shadow[23:20]);
  assign vr_out_hex6 = r_blank ? 7'h7F : hexFont(r_shadow[27:24]);
  assign vr_out_hex7 = r_blank ? 7'h7F : hexFont(r_shadow[31:28]);

endmodule

// File: tb/tb_varredor_de_registradores.sv
// Directed bench for the register scanner: a DWELL_CYCLES=4 instance drives most checks and a
// DWELL_CYCLES=10 instance checks periodic re-sampling.
module tb_varredor_de_registradores;

  logic        clk = 1'b0;
  logic        rstN;
  logic [4:0]  sw;
  logic        autoIn;
  logic        hold;
  logic        mapMode;
  logic [31:0] dataReg;
  logic [31:0] vrData;
  logic [4:0]  selA, ledrA, selB, ledrB;
  logic        validA, validB;
  logic [6:0]  hexA [8];
  logic [6:0]  hexB [8];
  logic [55:0] digitsA;

  int total = 0;
  int bad   = 0;

  localparam logic [55:0] DIG_BLANK    = {8{7'h7F}};
  localparam logic [55:0] DIG_12345678 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};
  localparam logic [55:0] DIG_DEADBEEF = {7'b0100001, 7'b0000110, 7'b0001000, 7'b0100001,
                                          7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110};
  localparam logic [55:0] DIG_000000A7 = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000,
                                          7'b1000000, 7'b1000000, 7'b0001000, 7'b1111000};

  always #5 clk = ~clk;

  // Register-file model: in map mode each index returns 0xA00000xx with xx = index.
  always_comb vrData = mapMode ? (32'hA0000000 | {27'd0, selA}) : dataReg;

  assign digitsA = {hexA[7], hexA[6], hexA[5], hexA[4], hexA[3], hexA[2], hexA[1], hexA[0]};

  varredor_de_registradores #(.DWELL_CYCLES(4)) dutA (
    .vr_in_clk(clk), .vr_in_rst_n(rstN), .vr_in_SW(sw), .vr_in_auto(autoIn),
    .vr_in_hold(hold), .vr_in_data(vrData), .vr_out_sel(selA),
    .vr_out_hex0(hexA[0]), .vr_out_hex1(hexA[1]), .vr_out_hex2(hexA[2]), .vr_out_hex3(hexA[3]),
    .vr_out_hex4(hexA[4]), .vr_out_hex5(hexA[5]), .vr_out_hex6(hexA[6]), .vr_out_hex7(hexA[7]),
    .vr_out_ledr(ledrA), .vr_out_valid(validA)
  );

  varredor_de_registradores #(.DWELL_CYCLES(10)) dutB (
    .vr_in_clk(clk), .vr_in_rst_n(rstN), .vr_in_SW(sw), .vr_in_auto(autoIn),
    .vr_in_hold(hold), .vr_in_data(vrData), .vr_out_sel(selB),
    .vr_out_hex0(hexB[0]), .vr_out_hex1(hexB[1]), .vr_out_hex2(hexB[2]), .vr_out_hex3(hexB[3]),
    .vr_out_hex4(hexB[4]), .vr_out_hex5(hexB[5]), .vr_out_hex6(hexB[6]), .vr_out_hex7(hexB[7]),
    .vr_out_ledr(ledrB), .vr_out_valid(validB)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] s, input logic a, input logic h,
                               input logic [31:0] d);
    sw      = s;
    autoIn  = a;
    hold    = h;
    dataReg = d;
  endtask

  task automatic waitDisplay(input logic [4:0] idx, input int limit);
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (validA && ledrA == idx) break;
    end
  endtask

  initial begin
    int dropAt;
    int doneAt;
    int gapAt;
    logic stable;

    mapMode = 1'b0;
    rstN    = 1'b0;
    applyStimulus(5'd5, 1'b0, 1'b0, 32'h12345678);
    repeat (2) @(negedge clk);
    checkOutput("reset_hex", digitsA, DIG_BLANK);
    checkOutput("reset_valid", validA, 1'b0);
    checkOutput("reset_sel", selA, 5'd0);

    rstN = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("no_cap_by_edge2", validA, 1'b0);
    @(negedge clk);
    checkOutput("cap_at_edge3", validA, 1'b1);
    checkOutput("cap_at_edge3_ledr", ledrA, 5'd0);
    waitDisplay(5'd5, 20);
    checkOutput("first_show5", validA && ledrA == 5'd5, 1'b1);

    // Asynchronous reset in the middle of a dwell period.
    repeat (2) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midreset_hex", digitsA, DIG_BLANK);
    checkOutput("midreset_valid", validA, 1'b0);
    checkOutput("midreset_ledr", ledrA, 5'd0);
    @(negedge clk);
    rstN = 1'b1;
    waitDisplay(5'd5, 20);
    checkOutput("after_reset_digits", digitsA, DIG_12345678);
    checkOutput("after_reset_ledr", ledrA, 5'd5);
    checkOutput("after_reset_valid", validA, 1'b1);

    // Re-sampling on the DWELL_CYCLES=10 instance.
    applyStimulus(5'd5, 1'b0, 1'b0, 32'h0000000F);
    doneAt = 0;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (hexB[0] == 7'b0001110) begin
        doneAt = i;
        break;
      end
    end
    checkOutput("resample_13", doneAt != 0, 1'b1);
    checkOutput("resample_ledr", ledrB, 5'd5);

    // Line up with a capture on the fast instance, then change the switches.
    applyStimulus(5'd5, 1'b0, 1'b0, 32'h0000000E);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (hexA[0] == 7'b0000110) break;
    end
    checkOutput("align_capture", hexA[0], 7'b0000110);

    applyStimulus(5'd29, 1'b0, 1'b0, 32'hDEADBEEF);
    dropAt = 0;
    doneAt = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (!validA && dropAt == 0) dropAt = i;
      if (validA && ledrA == 5'd29) begin
        doneAt = i;
        break;
      end
    end
    checkOutput("valid_drop_4", dropAt != 0 && dropAt <= 4, 1'b1);
    checkOutput("show29_7", doneAt != 0, 1'b1);
    checkOutput("show29_digits", digitsA, DIG_DEADBEEF);
    checkOutput("show29_sel", selA, 5'd29);

    // Hold: nothing may move for 100 cycles even though SW and data change.
    applyStimulus(5'd29, 1'b0, 1'b1, 32'hDEADBEEF);
    repeat (10) @(negedge clk);
    applyStimulus(5'd7, 1'b0, 1'b1, 32'h000000A7);
    stable = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (digitsA !== DIG_DEADBEEF || ledrA !== 5'd29 || validA !== 1'b1 || selA !== 5'd29)
        stable = 1'b0;
    end
    checkOutput("hold_frozen_100", stable, 1'b1);
    applyStimulus(5'd7, 1'b0, 1'b0, 32'h000000A7);
    waitDisplay(5'd7, 7);
    checkOutput("unhold_show7", validA && ledrA == 5'd7, 1'b1);
    checkOutput("unhold_digits", digitsA, DIG_000000A7);

`ifdef VARREDOR_AUTO_SCAN_EN
    mapMode = 1'b1;
    applyStimulus(5'd30, 1'b0, 1'b0, 32'h0);
    waitDisplay(5'd30, 8);
    checkOutput("auto_start30", validA && ledrA == 5'd30, 1'b1);
    checkOutput("auto_start30_hex", {hexA[1], hexA[0]}, {7'b1111001, 7'b0000110});
    applyStimulus(5'd30, 1'b1, 1'b0, 32'h0);
    waitDisplay(5'd31, 8);
    checkOutput("auto_show31", validA && ledrA == 5'd31, 1'b1);
    checkOutput("auto_sel31", selA, 5'd31);
    checkOutput("auto_hex31", {hexA[1], hexA[0]}, {7'b1111001, 7'b0001110});
    gapAt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ledrA == 5'd0) begin
        gapAt = i;
        break;
      end
    end
    checkOutput("auto_wrap_gap", gapAt, 7);
    checkOutput("auto_sel0", selA, 5'd0);
    checkOutput("auto_hex0", {hexA[7], hexA[1], hexA[0]}, {7'b0001000, 7'b1000000, 7'b1000000});
    gapAt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ledrA == 5'd1) begin
        gapAt = i;
        break;
      end
    end
    checkOutput("auto_next_gap", gapAt, 7);
    checkOutput("auto_sel1", selA, 5'd1);
    checkOutput("auto_hex1", hexA[0], 7'b1111001);
`else
    applyStimulus(5'd3, 1'b1, 1'b0, 32'h00000003);
    waitDisplay(5'd3, 8);
    checkOutput("manual_only_show3", validA && ledrA == 5'd3, 1'b1);
    stable = 1'b1;
    repeat (35) begin
      @(negedge clk);
      if (selA !== 5'd3 || ledrA !== 5'd3 || validA !== 1'b1) stable = 1'b0;
    end
    checkOutput("manual_only_sel_stays3", stable, 1'b1);
    checkOutput("manual_only_hex0", hexA[0], 7'b0110000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
